// File: rtl/vram_arb_pkg.sv
// -----------------------------------------------------------------------------
// vram_arb_pkg
// Shared types and constants for the VRAM access arbiter.
//   rd_state_t  : host read FSM states
//   ret_tag_t   : owner of the read data returning from the RAM next cycle
//   VRAM_ADDR_W : default byte-address width of the 128 KiB VRAM
// -----------------------------------------------------------------------------
package vram_arb_pkg;

    localparam int unsigned VRAM_ADDR_W = 17;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_PEND   = 2'd1,
        RD_ISSUED = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        VID  = 2'd1,
        HOST = 2'd2
    } ret_tag_t;

endpackage

// File: rtl/vram_arb_wfifo.sv
// -----------------------------------------------------------------------------
// vram_arb_wfifo
// Synchronous host write FIFO carrying {addr, data} entries.
// Ports:
//   clk, reset_n            : clock, synchronous active-low reset
//   push, push_addr/data    : enqueue (ignored when full)
//   pop                     : dequeue head (ignored when empty)
//   full, empty             : occupancy flags
//   head_addr, head_data    : oldest entry
//   match_addr, match       : combinational "any queued entry has this address"
// -----------------------------------------------------------------------------
module vram_arb_wfifo
    import vram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = VRAM_ADDR_W,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [7:0]        push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W-1:0] head_addr,
    output logic [7:0]        head_data,
    input  logic [ADDR_W-1:0] match_addr,
    output logic              match
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [7:0]        data_q [DEPTH];
    logic [IDX_W-1:0]  wr_idx, rd_idx;
    logic              do_push, do_pop;

    assign wr_idx = wr_ptr_q[IDX_W-1:0];
    assign rd_idx = rd_ptr_q[IDX_W-1:0];

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                   (wr_idx == rd_idx);

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        valid_d  = valid_q;
        if (do_push) begin
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            valid_d[wr_idx] = 1'b1;
        end
        // Push and pop never target the same slot: that needs full or empty.
        if (do_pop) begin
            rd_ptr_d        = rd_ptr_q + PTR_W'(1);
            valid_d[rd_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            valid_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            valid_q  <= valid_d;
        end
    end

    // Payload storage needs no reset; valid_q qualifies every use.
    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_q[wr_idx] <= push_addr;
            data_q[wr_idx] <= push_data;
        end
    end

    assign head_addr = addr_q[rd_idx];
    assign head_data = data_q[rd_idx];

    always_comb begin
        match = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (valid_q[i] && (addr_q[i] == match_addr)) begin
                match = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
// Single-port VRAM arbiter: video fetch has strict priority, host reads and
// buffered host writes use the idle cycles.
// Optional feature macro: VRAM_ARB_HOST_READ_EN (host read path, read FSM and
// read-after-write hazard check). Without it the host read outputs are 0.
// Ports:
//   clk, reset_n                 : clock, synchronous active-low reset
//   vid_req/addr, vid_valid/rdata: video fetch request and returned data
//   host_wr_*                    : host write request into the FIFO
//   host_rd_*                    : host read request, busy, valid, data
//   host_starved                 : sticky starvation flag
//   ram_*                        : registered single-port RAM interface
// -----------------------------------------------------------------------------
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = VRAM_ADDR_W,
    parameter int unsigned WFIFO_DEPTH  = 4,
    parameter int unsigned STARVE_LIMIT = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_valid,
    output logic [7:0]        vid_rdata,
    input  logic              host_wr_valid,
    output logic              host_wr_ready,
    input  logic [ADDR_W-1:0] host_wr_addr,
    input  logic [7:0]        host_wr_data,
    input  logic              host_rd_req,
    input  logic [ADDR_W-1:0] host_rd_addr,
    output logic              host_rd_busy,
    output logic              host_rd_valid,
    output logic [7:0]        host_rd_data,
    output logic              host_starved,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    // Write FIFO
    logic              fifo_full, fifo_empty, fifo_match, fifo_push;
    logic [ADDR_W-1:0] fifo_head_addr, match_addr;
    logic [7:0]        fifo_head_data;

    // Grants
    logic rd_pending, rd_grant, wr_grant, host_grant, host_pending;

    // Registered RAM interface and return path
    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]        ram_wdata_q, ram_wdata_d;
    ret_tag_t          tag_q, tag_d;
    logic              vid_valid_q, vid_valid_d;

    // Starvation tracking
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic              starved_q, starved_d;

    assign host_wr_ready = ~fifo_full;
    assign fifo_push     = host_wr_valid & host_wr_ready;

    vram_arb_wfifo #(
        .ADDR_W (ADDR_W),
        .DEPTH  (WFIFO_DEPTH)
    ) u_wfifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (fifo_push),
        .push_addr  (host_wr_addr),
        .push_data  (host_wr_data),
        .pop        (wr_grant),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head_addr  (fifo_head_addr),
        .head_data  (fifo_head_data),
        .match_addr (match_addr),
        .match      (fifo_match)
    );

`ifdef VRAM_ARB_HOST_READ_EN
    rd_state_t         rd_state_q, rd_state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              host_rd_valid_q, host_rd_valid_d;
    logic [7:0]        host_rd_data_q, host_rd_data_d;

    assign match_addr = rd_addr_q;
    assign rd_pending = (rd_state_q == RD_PEND);
    // A queued write to the same address must land before the read is issued.
    assign rd_grant   = rd_pending & ~vid_req & ~fifo_match;

    always_comb begin
        rd_state_d      = rd_state_q;
        rd_addr_d       = rd_addr_q;
        host_rd_valid_d = (tag_q == HOST);
        host_rd_data_d  = host_rd_data_q;
        if (host_rd_valid_q) begin
            host_rd_data_d = ram_rdata;
        end
        unique case (rd_state_q)
            RD_IDLE: begin
                if (host_rd_req) begin
                    rd_state_d = RD_PEND;
                    rd_addr_d  = host_rd_addr;
                end
            end
            RD_PEND: begin
                if (rd_grant) begin
                    rd_state_d = RD_ISSUED;
                end
            end
            RD_ISSUED: rd_state_d = RD_IDLE;
            default:   rd_state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_state_q      <= RD_IDLE;
            rd_addr_q       <= '0;
            host_rd_valid_q <= 1'b0;
            host_rd_data_q  <= '0;
        end else begin
            rd_state_q      <= rd_state_d;
            rd_addr_q       <= rd_addr_d;
            host_rd_valid_q <= host_rd_valid_d;
            host_rd_data_q  <= host_rd_data_d;
        end
    end

    assign host_rd_busy  = (rd_state_q != RD_IDLE);
    assign host_rd_valid = host_rd_valid_q;
    // RAM data is live in the valid cycle; the register holds it afterwards.
    assign host_rd_data  = host_rd_valid_q ? ram_rdata : host_rd_data_q;
`else
    logic unused_rd;

    assign match_addr    = '0;
    assign rd_pending    = 1'b0;
    assign rd_grant      = 1'b0;
    assign host_rd_busy  = 1'b0;
    assign host_rd_valid = 1'b0;
    assign host_rd_data  = '0;
    assign unused_rd     = ^{host_rd_req, host_rd_addr, fifo_match};
`endif

    // Priority: video > host read > write FIFO head.
    assign wr_grant     = ~vid_req & ~rd_grant & ~fifo_empty;
    assign host_grant   = rd_grant | wr_grant;
    assign host_pending = rd_pending | ~fifo_empty;

    always_comb begin
        ram_en_d    = vid_req | host_grant;
        ram_we_d    = wr_grant;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        tag_d       = NONE;
        if (vid_req) begin
            ram_addr_d = vid_addr;
            tag_d      = VID;
        end else if (rd_grant) begin
            ram_addr_d = match_addr;
            tag_d      = HOST;
        end else if (wr_grant) begin
            ram_addr_d  = fifo_head_addr;
            ram_wdata_d = fifo_head_data;
        end
        vid_valid_d = (tag_q == VID);
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (host_grant) begin
            starve_cnt_d = '0;
        end else if (host_pending && (starve_cnt_q != CNT_MAX)) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
        starved_d = starved_q | (starve_cnt_d == CNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ram_en_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            tag_q        <= NONE;
            vid_valid_q  <= 1'b0;
            starve_cnt_q <= '0;
            starved_q    <= 1'b0;
        end else begin
            ram_en_q     <= ram_en_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            tag_q        <= tag_d;
            vid_valid_q  <= vid_valid_d;
            starve_cnt_q <= starve_cnt_d;
            starved_q    <= starved_d;
        end
    end

    assign ram_en       = ram_en_q;
    assign ram_we       = ram_we_q;
    assign ram_addr     = ram_addr_q;
    assign ram_wdata    = ram_wdata_q;
    assign vid_valid    = vid_valid_q;
    // RAM data arrives in the same cycle the registered valid is high.
    assign vid_rdata    = vid_valid_q ? ram_rdata : 8'h00;
    assign host_starved = starved_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vram_arbiter
// Directed bench for vram_arbiter with a synchronous RAM model.
// Host read checks follow VRAM_ARB_HOST_READ_EN.
// -----------------------------------------------------------------------------
module tb_vram_arbiter;

    localparam int unsigned AW = 17;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_valid;
    logic [7:0]    vid_rdata;
    logic          host_wr_valid;
    logic          host_wr_ready;
    logic [AW-1:0] host_wr_addr;
    logic [7:0]    host_wr_data;
    logic          host_rd_req;
    logic [AW-1:0] host_rd_addr;
    logic          host_rd_busy;
    logic          host_rd_valid;
    logic [7:0]    host_rd_data;
    logic          host_starved;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_wdata;
    logic [7:0]    ram_rdata = 8'h00;

    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [7:0]    load_data;
    logic [7:0]    mem [2**AW];

    int n_cmp = 0;
    int n_err = 0;

    vram_arbiter #(
        .ADDR_W       (AW),
        .WFIFO_DEPTH  (4),
        .STARVE_LIMIT (16)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .vid_req       (vid_req),
        .vid_addr      (vid_addr),
        .vid_valid     (vid_valid),
        .vid_rdata     (vid_rdata),
        .host_wr_valid (host_wr_valid),
        .host_wr_ready (host_wr_ready),
        .host_wr_addr  (host_wr_addr),
        .host_wr_data  (host_wr_data),
        .host_rd_req   (host_rd_req),
        .host_rd_addr  (host_rd_addr),
        .host_rd_busy  (host_rd_busy),
        .host_rd_valid (host_rd_valid),
        .host_rd_data  (host_rd_data),
        .host_starved  (host_starved),
        .ram_en        (ram_en),
        .ram_we        (ram_we),
        .ram_addr      (ram_addr),
        .ram_wdata     (ram_wdata),
        .ram_rdata     (ram_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM: read data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset_n       = 1'b0;
        vid_req       = 1'b0;
        vid_addr      = '0;
        host_wr_valid = 1'b0;
        host_wr_addr  = '0;
        host_wr_data  = '0;
        host_rd_req   = 1'b0;
        host_rd_addr  = '0;
        load_en       = 1'b0;
        load_addr     = '0;
        load_data     = '0;

        // Preload video data while held in reset.
        for (int i = 0; i < 8; i++) begin
            load_en   = 1'b1;
            load_addr = AW'(i);
            load_data = 8'(i);
            tick();
        end
        load_en = 1'b0;

        check("rst_ram_en",    ram_en,        0);
        check("rst_ram_we",    ram_we,        0);
        check("rst_ram_addr",  ram_addr,      0);
        check("rst_ram_wdata", ram_wdata,     0);
        check("rst_vid_valid", vid_valid,     0);
        check("rst_vid_rdata", vid_rdata,     0);
        check("rst_rd_valid",  host_rd_valid, 0);
        check("rst_rd_busy",   host_rd_busy,  0);
        check("rst_rd_data",   host_rd_data,  0);
        check("rst_starved",   host_starved,  0);
        check("rst_wr_ready",  host_wr_ready, 1);
        reset_n = 1'b1;
        tick();

        // Video: 8 back-to-back fetches, 2-cycle latency.
        for (int c = 0; c < 10; c++) begin
            vid_req  = (c < 8);
            vid_addr = AW'(c);
            tick();
            check("vid_ram_en", ram_en, (c < 8));
            check("vid_ram_we", ram_we, 0);
            if (c < 8) check("vid_ram_addr", ram_addr, c);
            check("vid_valid", vid_valid, (c >= 1 && c <= 8));
            if (c >= 1 && c <= 8) check("vid_rdata", vid_rdata, c - 1);
        end
        vid_req = 1'b0;

        // Host write into idle RAM.
        host_wr_valid = 1'b1;
        host_wr_addr  = 17'h1FFFF;
        host_wr_data  = 8'hA5;
        check("wr_ready_idle", host_wr_ready, 1);
        tick();
        host_wr_valid = 1'b0;
        check("wr_not_yet", ram_en, 0);
        tick();
        check("wr_ram_we",    ram_we,    1);
        check("wr_ram_addr",  ram_addr,  32'h1FFFF);
        check("wr_ram_wdata", ram_wdata, 32'hA5);
        tick();
        check("wr_done_idle", ram_en, 0);

        // FIFO full behind continuous video traffic.
        vid_req  = 1'b1;
        vid_addr = '0;
        for (int k = 0; k < 4; k++) begin
            host_wr_valid = 1'b1;
            host_wr_addr  = AW'(32'h200 + k);
            host_wr_data  = 8'(8'h50 + k);
            check("ff_ready", host_wr_ready, 1);
            tick();
            check("ff_no_host_we", ram_we, 0);
        end
        host_wr_addr = 17'h002FF;
        check("ff_full_ready", host_wr_ready, 0);
        host_wr_valid = 1'b0;
        vid_req       = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("ff_drain_we",    ram_we,    1);
            check("ff_drain_addr",  ram_addr,  32'h200 + k);
            check("ff_drain_wdata", ram_wdata, 32'h50 + k);
        end
        tick();
        check("ff_drained", ram_en, 0);
        check("ff_ready_again", host_wr_ready, 1);

`ifdef VRAM_ARB_HOST_READ_EN
        // Read-after-write hazard: queued write must land before the read.
        vid_req       = 1'b1;
        host_wr_valid = 1'b1;
        host_wr_addr  = 17'h00100;
        host_wr_data  = 8'h3C;
        tick();
        host_wr_valid = 1'b0;
        host_rd_req   = 1'b1;
        host_rd_addr  = 17'h00100;
        tick();
        host_rd_req = 1'b0;
        check("raw_busy", host_rd_busy, 1);
        tick();
        vid_req = 1'b0;
        tick();
        check("raw_wr_first_we",   ram_we,   1);
        check("raw_wr_first_addr", ram_addr, 32'h100);
        tick();
        check("raw_rd_en",   ram_en,   1);
        check("raw_rd_we",   ram_we,   0);
        check("raw_rd_addr", ram_addr, 32'h100);
        tick();
        check("raw_rd_valid", host_rd_valid, 1);
        check("raw_rd_data",  host_rd_data,  32'h3C);
        tick();
        check("raw_valid_pulse", host_rd_valid, 0);
        check("raw_data_held",   host_rd_data,  32'h3C);
        check("raw_idle",        host_rd_busy,  0);
`else
        // Host reads are compiled out: requests are ignored.
        host_rd_req  = 1'b1;
        host_rd_addr = 17'h00100;
        tick();
        host_rd_req = 1'b0;
        check("nord_busy", host_rd_busy, 0);
        tick();
        check("nord_valid", host_rd_valid, 0);
        check("nord_ram_en", ram_en, 0);
        tick();
        check("nord_data", host_rd_data, 0);
`endif

        // Starvation: one pending write behind 16 cycles of video.
        vid_req       = 1'b1;
        host_wr_valid = 1'b1;
        host_wr_addr  = 17'h00300;
        host_wr_data  = 8'h77;
        tick();
        host_wr_valid = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        check("starve_before", host_starved, 0);
        tick();
        check("starve_set", host_starved, 1);
        vid_req = 1'b0;
        tick();
        check("starve_wr_we",   ram_we,   1);
        check("starve_wr_addr", ram_addr, 32'h300);
        tick();
        tick();
        check("starve_sticky", host_starved, 1);

        // Reset mid-operation with queued writes (and an issued read).
        vid_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            host_wr_valid = 1'b1;
            host_wr_addr  = AW'(32'h10 + k);
            host_wr_data  = 8'(k);
            tick();
        end
        host_wr_valid = 1'b0;
`ifdef VRAM_ARB_HOST_READ_EN
        host_rd_req  = 1'b1;
        host_rd_addr = 17'h00040;
        tick();
        host_rd_req = 1'b0;
`endif
        vid_req = 1'b0;
        tick();
        check("mid_issue_en", ram_en, 1);
`ifdef VRAM_ARB_HOST_READ_EN
        check("mid_issue_rd", ram_we, 0);
        check("mid_issue_busy", host_rd_busy, 1);
`endif
        reset_n = 1'b0;
        tick();
        check("mid_rst_rd_valid", host_rd_valid, 0);
        check("mid_rst_wr_ready", host_wr_ready, 1);
        check("mid_rst_ram_en",   ram_en,        0);
        check("mid_rst_vid_valid", vid_valid,    0);
        check("mid_rst_busy",     host_rd_busy,  0);
        check("mid_rst_starved",  host_starved,  0);
        reset_n = 1'b1;
        tick();
        check("post_rst_rd_valid", host_rd_valid, 0);
        check("post_rst_ram_en",   ram_en,        0);
        check("post_rst_vid_valid", vid_valid,    0);
        tick();
        check("post_rst_rd_valid2", host_rd_valid, 0);
        check("post_rst_ram_en2",   ram_en,        0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port VRAM access arbiter for the VERA demo video pipeline. It sits between the `verademo` pixel-fetch engine and the shared 128 KiB × 8 VRAM, and services host register-port writes and reads from the HPS/OSD side. Video fetch always has strict priority. Host accesses are buffered in a small write FIFO and one outstanding read, and are issued only in cycles the fetch engine leaves idle. The block runs entirely in the `clk_sys` domain.

## Interface
Parameters:
- `ADDR_W`, 17, VRAM address width in bytes.
- `WFIFO_DEPTH`, 4, host write FIFO entries; must be a power of two, ≥ 2.
- `STARVE_LIMIT`, 1024, number of consecutive cycles with host work pending and no host grant before `host_starved` is set.

Ports:
- `clk`  in  1  system clock (`clk_sys`).
- `reset_n`  in  1  reset; **synchronous, active-low**.
- `vid_req`  in  1  fetch engine requests a read this cycle.
- `vid_addr`  in  ADDR_W  fetch address.
- `vid_valid`  out  1  fetch read data valid.
- `vid_rdata`  out  8  fetch read data.
- `host_wr_valid`  in  1  host write request.
- `host_wr_ready`  out  1  write FIFO not full.
- `host_wr_addr`  in  ADDR_W  host write address.
- `host_wr_data`  in  8  host write data.
- `host_rd_req`  in  1  host read request; single-cycle pulse, ignored while busy.
- `host_rd_addr`  in  ADDR_W  host read address.
- `host_rd_busy`  out  1  a host read is outstanding.
- `host_rd_valid`  out  1  host read data valid; one-cycle pulse.
- `host_rd_data`  out  8  host read data; held until the next read completes.
- `host_starved`  out  1  sticky starvation flag; cleared by reset.
- `ram_en`  out  1  RAM access strobe.
- `ram_we`  out  1  RAM write enable.
- `ram_addr`  out  ADDR_W  RAM address.
- `ram_wdata`  out  8  RAM write data.
- `ram_rdata`  in  8  RAM read data, valid one cycle after a read strobe.

## Operation
- **Per-cycle grant priority:** video > host read > host write FIFO head. At most one RAM access is issued per cycle.
- **Video path:** a `vid_req` sampled at edge N is always granted. The fetch engine needs no ready signal.
- **Write FIFO:**
  - Accepts an entry when `host_wr_valid & host_wr_ready`.
  - A simultaneous push and pop while full is legal; `host_wr_ready` stays 0 that cycle. The pop frees the slot for the next cycle.
  - Pointers have `log2(WFIFO_DEPTH)+1` bits and wrap modulo 2×depth. Full: MSBs differ and the rest are equal. Empty: pointers equal.
- **Read FSM:**
  - `RD_IDLE` → `RD_PEND` on `host_rd_req`; address is latched.
  - `RD_PEND` → `RD_ISSUED` when the grant is won.
  - `RD_ISSUED` → `RD_IDLE` next cycle, with `host_rd_valid` pulsed and data captured.
  - `host_rd_busy = (state != RD_IDLE)`.
  - A `host_rd_req` that arrives while busy is dropped.
- **Hazard:** a host read must not bypass an older write to the same address. While the FIFO holds any entry whose address matches the pending read address, the read loses to writes until the match drains.
- **Starvation counter:**
  - Increments each cycle that host work is pending and not granted.
  - Clears to 0 on any host grant.
  - Saturates at `STARVE_LIMIT`; when it reaches the limit it sets `host_starved`.
- **Tag pipeline:** a one-deep return tag (`NONE`/`VID`/`HOST`) follows every read strobe and routes `ram_rdata` to the correct requester.

## Timing
- **Issue:** the request is sampled at edge N. `ram_*` is registered and asserted during cycle N+1. `ram_rdata` returns in cycle N+2. `vid_valid`/`vid_rdata` and `host_rd_valid` are registered and valid in cycle N+2.
- **Video latency:** exactly 2 cycles. Back-to-back fetches give one result per cycle.
- **Host write:** at the earliest, the RAM write strobe occurs 2 cycles after acceptance into an empty FIFO with no video traffic.
- **Reset values (`reset_n` = 0 at an edge):**
  - `ram_en`/`ram_we`, `vid_valid`, `host_rd_valid`, `host_rd_busy`, `host_starved` = 0.
  - `ram_addr`, `ram_wdata`, `vid_rdata`, `host_rd_data` = 0.
  - `host_wr_ready` = 1 from the first cycle after reset.
  - FIFO empties, read FSM returns to `RD_IDLE`, return tag becomes `NONE`, starvation counter clears.
  - In-flight reads are discarded: no valid pulse is produced after reset.

## Configuration
- **Macro:** `VRAM_ARB_HOST_READ_EN`.
- **With the macro defined:** host read path, read FSM and hazard check are present as described.
- **Without the macro:**
  - `host_rd_busy`, `host_rd_valid` and `host_rd_data` are tied to 0.
  - `host_rd_req` is ignored.
  - The tag pipeline reduces to video-only.

## Structure
- **Package `vram_arb_pkg`:** `rd_state_t` enum, `ret_tag_t` enum, and the `VRAM_ADDR_W` default constant.
- **Sub-module `vram_arb_wfifo`:** synchronous FIFO carrying `{addr, data}`, with `push`/`pop`/`full`/`empty` and a combinational address-match output used by the hazard check.

## Test plan
- **Video latency:** `vid_req` continuous for 8 cycles, addrs 0x00000–0x00007 → `ram_en` during cycles 1–8; `vid_valid` during cycles 2–9 with data 0x00–0x07 preloaded; no host grants.
- **Host write into idle RAM:** host writes 0x1FFFF←0xA5 → `ram_we` with `ram_addr`=0x1FFFF and `ram_wdata`=0xA5 two cycles after acceptance.
- **FIFO full:**
  - `vid_req` held high; 4 host writes accepted.
  - 5th write: `host_wr_ready`=0.
  - Drop `vid_req`: 4 writes issue in order on consecutive cycles.
- **Read-after-write hazard:** queue a write 0x00100←0x3C, then read 0x00100 → write strobe precedes read strobe; `host_rd_data`=0x3C.
- **Starvation:** `STARVE_LIMIT`=16, `vid_req` held with one host write pending → `host_starved`=1 after 16 cycles; stays 1 after `vid_req` drops until reset.
- **Reset mid-operation:** `reset_n`=0 for 1 cycle with a host read in `RD_ISSUED` and 3 FIFO entries → no `host_rd_valid`, `host_wr_ready`=1, no `ram_en` in the following cycle.
